// File: rtl/tile_pixel_renderer_if.sv
`default_nettype none
// ============================================================================
//  Module      : tile_pixel_renderer_if
//  Description : Pixel-stream bus for tile_pixel_renderer. It groups the
//                scan-out pixel request, the maze map RAM read port and the
//                composited RGB output.
//                  frame_start  1-cycle pulse at the start of each frame
//                  pix_valid    pix_x/pix_y valid this cycle
//                  pix_x/pix_y  10-bit screen pixel coordinate
//                  map_addr     10-bit maze map RAM address
//                  map_rdata    2-bit tile code, 1-cycle synchronous read
//                  out_valid    out_r/g/b valid
//                  out_r/g/b    4-bit colour components
//                The master modport is the pixel source/map RAM side. The
//                slave modport is the renderer.
//  Revision    : 1.0  initial release
// ============================================================================
interface tile_pixel_renderer_if;
   logic       frame_start;
   logic       pix_valid;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic [9:0] map_addr;
   logic [1:0] map_rdata;
   logic       out_valid;
   logic [3:0] out_r;
   logic [3:0] out_g;
   logic [3:0] out_b;

   modport master (
      output frame_start, pix_valid, pix_x, pix_y, map_rdata,
      input  map_addr, out_valid, out_r, out_g, out_b
   );

   modport slave (
      input  frame_start, pix_valid, pix_x, pix_y, map_rdata,
      output map_addr, out_valid, out_r, out_g, out_b
   );
endinterface
`default_nettype wire

// File: rtl/tile_pixel_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tile_pixel_renderer
//  Description : Per-pixel compositor. It looks up the maze tile under each
//                scan-out pixel, overlays the player and ghost sprites and
//                emits 4-bit RGB through a fixed 3-cycle pipeline. It latches
//                the sprite positions once per frame and runs the two-phase
//                animation counter.
//  Ports       : clk, rst (asynchronous, active-high)
//                bus       tile_pixel_renderer_if.slave (pixel in, map RAM,
//                          RGB out)
//                player_x/y, ghost_x/y, ghost_dir : sprite state, latched
//                          on frame_start
//                background_r/g/b, wall_r/g/b     : 4-bit-per-pixel tile
//                          colour planes
//                dot/big_dot/player/ghost masks   : 1-bit-per-pixel masks
//                ghost_sclera/eye masks           : per-direction eye masks
//  Config      : `define GHOST_EYES_EN to draw ghost sclera and eyes. Without
//                it the eye ports are ignored and the ghost is solid red.
//  Notes       : TILE_SIZE must be a power of two.
//  Revision    : 1.0  initial release
// ============================================================================
module tile_pixel_renderer #(
   parameter int TILE_SIZE   = 16,
   parameter int MAP_W       = 28,
   parameter int MAP_H       = 31,
   parameter int ANIM_FRAMES = 8
) (
   input wire                              clk,
   input wire                              rst,
   tile_pixel_renderer_if.slave            bus,
   input wire [9:0]                        player_x,
   input wire [9:0]                        player_y,
   input wire [9:0]                        ghost_x,
   input wire [9:0]                        ghost_y,
   input wire [1:0]                        ghost_dir,
   input wire [TILE_SIZE*TILE_SIZE*4-1:0]  background_r,
   input wire [TILE_SIZE*TILE_SIZE*4-1:0]  background_g,
   input wire [TILE_SIZE*TILE_SIZE*4-1:0]  background_b,
   input wire [TILE_SIZE*TILE_SIZE*4-1:0]  wall_r,
   input wire [TILE_SIZE*TILE_SIZE*4-1:0]  wall_g,
   input wire [TILE_SIZE*TILE_SIZE*4-1:0]  wall_b,
   input wire [TILE_SIZE*TILE_SIZE-1:0]    dot_mask,
   input wire [TILE_SIZE*TILE_SIZE-1:0]    big_dot_mask,
   input wire [TILE_SIZE*TILE_SIZE-1:0]    player_mask_f1,
   input wire [TILE_SIZE*TILE_SIZE-1:0]    player_mask_f2,
   input wire [TILE_SIZE*TILE_SIZE-1:0]    ghost_mask_f1,
   input wire [TILE_SIZE*TILE_SIZE-1:0]    ghost_mask_f2,
   input wire [TILE_SIZE*TILE_SIZE*4-1:0]  ghost_sclera_mask_up,
   input wire [TILE_SIZE*TILE_SIZE*4-1:0]  ghost_sclera_mask_down,
   input wire [TILE_SIZE*TILE_SIZE*4-1:0]  ghost_sclera_mask_left,
   input wire [TILE_SIZE*TILE_SIZE*4-1:0]  ghost_sclera_mask_right,
   input wire [TILE_SIZE*TILE_SIZE*4-1:0]  ghost_eye_mask_up,
   input wire [TILE_SIZE*TILE_SIZE*4-1:0]  ghost_eye_mask_down,
   input wire [TILE_SIZE*TILE_SIZE*4-1:0]  ghost_eye_mask_left,
   input wire [TILE_SIZE*TILE_SIZE*4-1:0]  ghost_eye_mask_right
);

   localparam int LOG_T  = $clog2(TILE_SIZE);
   localparam int IDX_W  = 2 * LOG_T;
   localparam int CNT_W  = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

   localparam logic [9:0]       C_TILE     = 10'(TILE_SIZE);
   localparam logic [9:0]       C_MAP_PX_W = 10'(MAP_W * TILE_SIZE);
   localparam logic [9:0]       C_MAP_PX_H = 10'(MAP_H * TILE_SIZE);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(ANIM_FRAMES - 1);

   localparam logic [1:0] G_NONE   = 2'd0;
   localparam logic [1:0] G_BODY   = 2'd1;
   localparam logic [1:0] G_SCLERA = 2'd2;
   localparam logic [1:0] G_EYE    = 2'd3;

   // ---------------------------------------------------------------------
   // Per-frame sprite snapshot and animation phase
   // ---------------------------------------------------------------------
   logic [9:0]       r_player_x, r_player_y, r_ghost_x, r_ghost_y;
   logic [1:0]       r_ghost_dir;
   logic [CNT_W-1:0] r_anim_cnt;
   logic             r_anim_phase;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_player_x   <= '0;
         r_player_y   <= '0;
         r_ghost_x    <= '0;
         r_ghost_y    <= '0;
         r_ghost_dir  <= '0;
         r_anim_cnt   <= '0;
         r_anim_phase <= 1'b0;
      end else if (bus.frame_start) begin
         r_player_x  <= player_x;
         r_player_y  <= player_y;
         r_ghost_x   <= ghost_x;
         r_ghost_y   <= ghost_y;
         r_ghost_dir <= ghost_dir;
         if (r_anim_cnt == C_CNT_LAST) begin
            r_anim_cnt   <= '0;
            r_anim_phase <= ~r_anim_phase;
         end else begin
            r_anim_cnt <= r_anim_cnt + CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 0: capture the pixel. Sprite offsets and the animation phase are
   // taken here from the pre-update snapshot so a pixel sampled together
   // with frame_start still sees the previous frame's state.
   // ---------------------------------------------------------------------
   logic [9:0] w_p_dx, w_p_dy, w_g_dx, w_g_dy;
   logic       w_p_hit, w_g_hit;

   // 10-bit unsigned differences: the >= guards reject the wrapped case.
   assign w_p_dx  = bus.pix_x - r_player_x;
   assign w_p_dy  = bus.pix_y - r_player_y;
   assign w_g_dx  = bus.pix_x - r_ghost_x;
   assign w_g_dy  = bus.pix_y - r_ghost_y;
   assign w_p_hit = (bus.pix_x >= r_player_x) && (w_p_dx < C_TILE) &&
                    (bus.pix_y >= r_player_y) && (w_p_dy < C_TILE);
   assign w_g_hit = (bus.pix_x >= r_ghost_x) && (w_g_dx < C_TILE) &&
                    (bus.pix_y >= r_ghost_y) && (w_g_dy < C_TILE);

   logic             r_s0_valid, r_s0_phase, r_s0_p_hit, r_s0_g_hit;
   logic [9:0]       r_s0_x, r_s0_y;
   logic [1:0]       r_s0_gdir;
   logic [IDX_W-1:0] r_s0_p_idx, r_s0_g_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s0_valid <= 1'b0;
         r_s0_x     <= '0;
         r_s0_y     <= '0;
         r_s0_phase <= 1'b0;
         r_s0_gdir  <= '0;
         r_s0_p_hit <= 1'b0;
         r_s0_g_hit <= 1'b0;
         r_s0_p_idx <= '0;
         r_s0_g_idx <= '0;
      end else begin
         r_s0_valid <= bus.pix_valid;
         r_s0_x     <= bus.pix_x;
         r_s0_y     <= bus.pix_y;
         r_s0_phase <= r_anim_phase;
         r_s0_gdir  <= r_ghost_dir;
         r_s0_p_hit <= w_p_hit;
         r_s0_g_hit <= w_g_hit;
         r_s0_p_idx <= {w_p_dy[LOG_T-1:0], w_p_dx[LOG_T-1:0]};
         r_s0_g_idx <= {w_g_dy[LOG_T-1:0], w_g_dx[LOG_T-1:0]};
      end
   end

   // Map address from the registered coordinate; off-map pixels read tile 0.
   logic        w_off;
   logic [19:0] w_addr_full;

   assign w_off       = (r_s0_x >= C_MAP_PX_W) || (r_s0_y >= C_MAP_PX_H);
   assign w_addr_full = 20'(r_s0_y >> LOG_T) * 20'(MAP_W) + 20'(r_s0_x >> LOG_T);
   assign bus.map_addr = w_off ? 10'd0 : w_addr_full[9:0];

   // ---------------------------------------------------------------------
   // Stage 1: resolve every mask and plane lookup that does not depend on
   // the tile code, so stage 2 is just a priority mux on map_rdata.
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0]   w_loc_idx;
   logic [IDX_W+1:0]   w_nib_base;
   logic               w_p_bit, w_g_body, w_eye_bit, w_sclera_bit;
   logic [1:0]         w_gsel;

   assign w_loc_idx  = {r_s0_y[LOG_T-1:0], r_s0_x[LOG_T-1:0]};
   assign w_nib_base = {w_loc_idx, 2'b00};
   assign w_p_bit    = r_s0_p_hit &&
                       (r_s0_phase ? player_mask_f2[r_s0_p_idx] : player_mask_f1[r_s0_p_idx]);
   assign w_g_body   = r_s0_phase ? ghost_mask_f2[r_s0_g_idx] : ghost_mask_f1[r_s0_g_idx];

`ifdef GHOST_EYES_EN
   logic [IDX_W+1:0] w_g_eidx;
   assign w_g_eidx = {2'b00, r_s0_g_idx};

   always_comb begin
      w_eye_bit    = 1'b0;
      w_sclera_bit = 1'b0;
      case (r_s0_gdir)
         2'd0: begin
            w_eye_bit    = ghost_eye_mask_up[w_g_eidx];
            w_sclera_bit = ghost_sclera_mask_up[w_g_eidx];
         end
         2'd1: begin
            w_eye_bit    = ghost_eye_mask_down[w_g_eidx];
            w_sclera_bit = ghost_sclera_mask_down[w_g_eidx];
         end
         2'd2: begin
            w_eye_bit    = ghost_eye_mask_left[w_g_eidx];
            w_sclera_bit = ghost_sclera_mask_left[w_g_eidx];
         end
         default: begin
            w_eye_bit    = ghost_eye_mask_right[w_g_eidx];
            w_sclera_bit = ghost_sclera_mask_right[w_g_eidx];
         end
      endcase
   end
`else
   assign w_eye_bit    = 1'b0;
   assign w_sclera_bit = 1'b0;
`endif

   // Eye and sclera override the body even where the body bit is clear.
   always_comb begin
      w_gsel = G_NONE;
      if (r_s0_g_hit) begin
         if (w_eye_bit)         w_gsel = G_EYE;
         else if (w_sclera_bit) w_gsel = G_SCLERA;
         else if (w_g_body)     w_gsel = G_BODY;
      end
   end

   // Upper eye-mask bits are never addressed; without eyes the masks and the
   // latched direction are not used at all.
   logic w_unused;
   assign w_unused = ^{ghost_sclera_mask_up, ghost_sclera_mask_down,
                       ghost_sclera_mask_left, ghost_sclera_mask_right,
                       ghost_eye_mask_up, ghost_eye_mask_down,
                       ghost_eye_mask_left, ghost_eye_mask_right,
                       r_s0_gdir, w_addr_full[19:10]};

   logic        r_s1_valid, r_s1_off, r_s1_phase, r_s1_player, r_s1_dot, r_s1_big;
   logic [1:0]  r_s1_gsel;
   logic [11:0] r_s1_wall, r_s1_bg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_off    <= 1'b0;
         r_s1_phase  <= 1'b0;
         r_s1_player <= 1'b0;
         r_s1_dot    <= 1'b0;
         r_s1_big    <= 1'b0;
         r_s1_gsel   <= G_NONE;
         r_s1_wall   <= '0;
         r_s1_bg     <= '0;
      end else begin
         r_s1_valid  <= r_s0_valid;
         r_s1_off    <= w_off;
         r_s1_phase  <= r_s0_phase;
         r_s1_player <= w_p_bit;
         r_s1_dot    <= dot_mask[w_loc_idx];
         r_s1_big    <= big_dot_mask[w_loc_idx];
         r_s1_gsel   <= w_gsel;
         r_s1_wall   <= {wall_r[w_nib_base +: 4], wall_g[w_nib_base +: 4],
                         wall_b[w_nib_base +: 4]};
         r_s1_bg     <= {background_r[w_nib_base +: 4], background_g[w_nib_base +: 4],
                         background_b[w_nib_base +: 4]};
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: priority colour select with the tile code from the map RAM.
   // ---------------------------------------------------------------------
   logic [11:0] w_rgb;

   always_comb begin
      w_rgb = r_s1_bg;
      if (r_s1_off)                                      w_rgb = 12'h000;
      else if (r_s1_gsel == G_EYE)                       w_rgb = 12'h00F;
      else if (r_s1_gsel == G_SCLERA)                    w_rgb = 12'hFFF;
      else if (r_s1_gsel == G_BODY)                      w_rgb = 12'hF00;
      else if (r_s1_player)                              w_rgb = 12'hFF0;
      else if (bus.map_rdata == 2'd2 && r_s1_dot)        w_rgb = 12'hFB9;
      else if (bus.map_rdata == 2'd3 && r_s1_big && !r_s1_phase)
                                                         w_rgb = 12'hFB9;
      else if (bus.map_rdata == 2'd1)                    w_rgb = r_s1_wall;
   end

   // Bubbles clear out_valid but leave the last colour on out_r/g/b.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_r     <= '0;
         bus.out_g     <= '0;
         bus.out_b     <= '0;
      end else begin
         bus.out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            bus.out_r <= w_rgb[11:8];
            bus.out_g <= w_rgb[7:4];
            bus.out_b <= w_rgb[3:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tile_pixel_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_pixel_renderer
//  Description : Directed self-checking bench for tile_pixel_renderer. It
//                models the maze map RAM as a 1-cycle synchronous read and
//                compares address, latency and colour against hand-computed
//                values. Expectations for ghost pixels follow GHOST_EYES_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tile_pixel_renderer;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   tile_pixel_renderer_if bus ();

   logic [9:0]    player_x, player_y, ghost_x, ghost_y;
   logic [1:0]    ghost_dir;
   logic [1023:0] bg_r, bg_g, bg_b, wall_r, wall_g, wall_b;
   logic [255:0]  dot_mask, big_dot_mask, pm_f1, pm_f2, gm_f1, gm_f2;
   logic [1023:0] scl_up, scl_down, scl_left, scl_right;
   logic [1023:0] eye_up, eye_down, eye_left, eye_right;
   logic [1:0]    tile_mem [0:1023];

   tile_pixel_renderer dut (
      .clk                     (clk),
      .rst                     (rst),
      .bus                     (bus),
      .player_x                (player_x),
      .player_y                (player_y),
      .ghost_x                 (ghost_x),
      .ghost_y                 (ghost_y),
      .ghost_dir               (ghost_dir),
      .background_r            (bg_r),
      .background_g            (bg_g),
      .background_b            (bg_b),
      .wall_r                  (wall_r),
      .wall_g                  (wall_g),
      .wall_b                  (wall_b),
      .dot_mask                (dot_mask),
      .big_dot_mask            (big_dot_mask),
      .player_mask_f1          (pm_f1),
      .player_mask_f2          (pm_f2),
      .ghost_mask_f1           (gm_f1),
      .ghost_mask_f2           (gm_f2),
      .ghost_sclera_mask_up    (scl_up),
      .ghost_sclera_mask_down  (scl_down),
      .ghost_sclera_mask_left  (scl_left),
      .ghost_sclera_mask_right (scl_right),
      .ghost_eye_mask_up       (eye_up),
      .ghost_eye_mask_down     (eye_down),
      .ghost_eye_mask_left     (eye_left),
      .ghost_eye_mask_right    (eye_right)
   );

   // Map RAM: registered read of the address presented this cycle.
   always @(posedge clk) bus.map_rdata <= tile_mem[bus.map_addr];

`ifdef GHOST_EYES_EN
   localparam logic [11:0] EXP_GHOST_136 = 12'h00F;   // eye bit
   localparam logic [11:0] EXP_GHOST_137 = 12'hFFF;   // sclera bit
`else
   localparam logic [11:0] EXP_GHOST_136 = 12'hF00;   // body bit
   localparam logic [11:0] EXP_GHOST_137 = 12'h897;   // background idx 0x89
`endif

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic pulse_frame();
      @(negedge clk);
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
   endtask

   // One pixel through the pipe: address one cycle after capture, output
   // exactly three cycles after capture.
   task automatic run_pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                            input logic fs, input logic [9:0] exp_addr,
                            input logic [11:0] exp_rgb);
      @(negedge clk);
      bus.pix_valid   = 1'b1;
      bus.pix_x       = x;
      bus.pix_y       = y;
      bus.frame_start = fs;
      @(posedge clk);
      #1;
      bus.pix_valid   = 1'b0;
      bus.frame_start = 1'b0;
      chk({tag, ":addr"}, 32'(bus.map_addr), 32'(exp_addr));
      chk({tag, ":lat1"}, 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, ":lat2"}, 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, ":valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ":rgb"}, 32'({bus.out_r, bus.out_g, bus.out_b}), 32'(exp_rgb));
   endtask

   initial begin
      int seen;
      logic [7:0] ii;

      bus.frame_start = 1'b0;
      bus.pix_valid   = 1'b0;
      bus.pix_x       = '0;
      bus.pix_y       = '0;
      player_x = 10'd32;  player_y = 10'd32;
      ghost_x  = 10'd200; ghost_y  = 10'd200;
      ghost_dir = 2'd0;
      for (int i = 0; i < 256; i++) begin
         ii = 8'(i);
         wall_r[i*4 +: 4] = ii[3:0];
         wall_g[i*4 +: 4] = ~ii[3:0];
         wall_b[i*4 +: 4] = ii[7:4];
         bg_r[i*4 +: 4]   = ii[7:4];
         bg_g[i*4 +: 4]   = ii[3:0];
         bg_b[i*4 +: 4]   = 4'h7;
      end
      dot_mask = '0; big_dot_mask = '0; pm_f1 = '0; pm_f2 = '0; gm_f1 = '0; gm_f2 = '0;
      scl_up = '0; scl_down = '0; scl_left = '0; scl_right = '0;
      eye_up = '0; eye_down = '0; eye_left = '0; eye_right = '0;
      dot_mask[86]     = 1'b1;   // pixel (70,5): row 5, col 6
      big_dot_mask[136] = 1'b1;  // row 8, col 8
      pm_f1[136] = 1'b1;
      pm_f2[137] = 1'b1;
      gm_f1[136] = 1'b1;
      eye_up[136] = 1'b1;
      scl_up[137] = 1'b1;
      for (int i = 0; i < 1024; i++) tile_mem[i] = 2'd0;
      tile_mem[0]   = 2'd1;   // wall at tile (0,0)
      tile_mem[4]   = 2'd2;   // dot at tile (4,0)
      tile_mem[58]  = 2'd3;   // big dot at tile (2,2)
      tile_mem[867] = 2'd1;   // last on-map tile (27,30)

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset:out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset:rgb", 32'({bus.out_r, bus.out_g, bus.out_b}), 32'd0);
      chk("reset:map_addr", 32'(bus.map_addr), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      pulse_frame();                                   // frame 1: player (32,32)
      run_pixel("wall_5_5",     10'd5,   10'd5,   1'b0, 10'd0,   12'h5A5);
      run_pixel("bg_37_50",     10'd37,  10'd50,  1'b0, 10'd86,  12'h257);
      run_pixel("dot_70_5",     10'd70,  10'd5,   1'b0, 10'd4,   12'hFB9);
      run_pixel("nodot_71_5",   10'd71,  10'd5,   1'b0, 10'd4,   12'h577);
      run_pixel("offmap_900",   10'd900, 10'd10,  1'b0, 10'd0,   12'h000);
      run_pixel("offmap_448",   10'd448, 10'd0,   1'b0, 10'd0,   12'h000);
      run_pixel("edge_447_495", 10'd447, 10'd495, 1'b0, 10'd867, 12'hF0F);
      run_pixel("player_40",    10'd40,  10'd40,  1'b0, 10'd58,  12'hFF0);

      // Player moves mid-frame: snapshot holds until the next frame_start
      player_x = 10'd100;
      run_pixel("snap_hold",    10'd40,  10'd40,  1'b0, 10'd58,  12'hFF0);
      pulse_frame();                                   // frame 2
      run_pixel("snap_new",     10'd40,  10'd40,  1'b0, 10'd58,  12'hFB9);

      // Ghost over player
      player_x = 10'd32;
      ghost_x  = 10'd32; ghost_y = 10'd32;
      pulse_frame();                                   // frame 3
      run_pixel("ghost_wins",   10'd40,  10'd40,  1'b0, 10'd58,  EXP_GHOST_136);
      run_pixel("ghost_137",    10'd41,  10'd40,  1'b0, 10'd58,  EXP_GHOST_137);

      // frame_start with a pixel: that pixel still sees the old ghost
      ghost_x = 10'd300;
      run_pixel("fs_same_cyc",  10'd40,  10'd40,  1'b1, 10'd58,  EXP_GHOST_136); // frame 4
      run_pixel("fs_next",      10'd40,  10'd40,  1'b0, 10'd58,  12'hFF0);

      // Animation: frames 5..7, then the wrapping frame 8 lands with a pixel
      repeat (3) pulse_frame();
      run_pixel("anim_cnt7",    10'd40,  10'd40,  1'b0, 10'd58,  12'hFF0);
      run_pixel("anim_wrap_px", 10'd40,  10'd40,  1'b1, 10'd58,  12'hFF0);
      run_pixel("anim_bigdot",  10'd40,  10'd40,  1'b0, 10'd58,  12'h887);
      run_pixel("anim_f2",      10'd41,  10'd40,  1'b0, 10'd58,  12'hFF0);

      // Reset with three pixels in flight
      @(negedge clk);
      bus.pix_valid = 1'b1; bus.pix_x = 10'd5;  bus.pix_y = 10'd5;
      @(negedge clk);
      bus.pix_x = 10'd40; bus.pix_y = 10'd40;
      @(negedge clk);
      bus.pix_x = 10'd70; bus.pix_y = 10'd5;
      @(posedge clk);
      #1;
      bus.pix_valid = 1'b0;
      chk("rst:pre_valid", 32'(bus.out_valid), 32'd1);
      chk("rst:pre_rgb", 32'({bus.out_r, bus.out_g, bus.out_b}), 32'h5A5);
      rst = 1'b1;
      #1;
      chk("rst:async_valid", 32'(bus.out_valid), 32'd0);
      chk("rst:async_rgb", 32'({bus.out_r, bus.out_g, bus.out_b}), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen++;
      end
      chk("rst:no_stale", 32'(seen), 32'd0);

      // After reset: snapshot at (0,0), phase 0, big dot visible again
      run_pixel("post_rst_wall", 10'd5,  10'd5,  1'b0, 10'd0,  12'h5A5);
      run_pixel("post_rst_big",  10'd40, 10'd40, 1'b0, 10'd58, 12'hFB9);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
